fifo_stream_reader: RTL and testbench

Drains the first-word-fall-through line FIFO of the median filter datapath and presents its contents as a valid/ready pixel stream with end-of-line and start-of-frame markers. It sits between the FIFO read port (`rd_en`/`dout`/`empty`) and the downstream window or filter stage. It owns frame geometry: it reads exactly `C_IMG_WIDTH*C_IMG_HEIGHT` words per frame, then inserts a programmable idle gap.

---
 rtl/fifo_stream_reader.sv | 137 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through line FIFO into a valid/ready pixel stream with
// end-of-line (m_tlast) and start-of-frame (m_tuser) markers; FIFO_STREAM_READER_TUSER_EN enables m_tuser.
//   state  | meaning
//   IDLE   | waiting for en, line/row counters held at 0
//   STREAM | popping W*H words from the FIFO into the output register
//   DRAIN  | last pixel of the frame read, waiting for it to be accepted
//   GAP    | inter-frame idle time, C_FRAME_GAP cycles
module fifo_stream_reader #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_IMG_WIDTH  = 640,
    parameter int C_IMG_HEIGHT = 480,
    parameter int C_FRAME_GAP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [C_DATA_WIDTH-1:0] fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tuser,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int COL_W    = (C_IMG_WIDTH > 1) ? $clog2(C_IMG_WIDTH) : 1;
    localparam int ROW_W    = (C_IMG_HEIGHT > 1) ? $clog2(C_IMG_HEIGHT) : 1;
    localparam int GAP_W    = (C_FRAME_GAP > 1) ? $clog2(C_FRAME_GAP) : 1;
    localparam int GAP_LOAD = (C_FRAME_GAP > 0) ? C_FRAME_GAP - 1 : 0;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(C_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(C_IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [GAP_W-1:0] gap_cnt;
    logic             col_last;
    logic             row_last;
    logic             accept;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign accept   = m_tvalid & m_tready;
    assign busy     = (state != IDLE);

    // Gated by rst so the FIFO head survives a reset that lands mid-frame.
    assign fifo_rd_en = ~rst & (state == STREAM) & ~fifo_empty & (~m_tvalid | m_tready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = STREAM;
            STREAM:  if (fifo_rd_en && col_last && row_last) state_nxt = DRAIN;
            DRAIN:   if (accept) state_nxt = (C_FRAME_GAP == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Down-counter loaded on entry to GAP; terminal count 0 releases to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if ((state == DRAIN) && accept) begin
            gap_cnt <= GAP_W'(GAP_LOAD);
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE)) begin
            col <= '0;
            row <= '0;
        end else if (fifo_rd_en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) & accept;
            if (fifo_rd_en) begin
                m_tdata  <= fifo_dout;
                m_tvalid <= 1'b1;
                m_tlast  <= col_last;
            end else if (accept) begin
                m_tvalid <= 1'b0;
            end
        end
    end

`ifdef FIFO_STREAM_READER_TUSER_EN
    logic tuser_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tuser_q <= 1'b0;
        end else if (fifo_rd_en) begin
            tuser_q <= (col == '0) && (row == '0);
        end
    end

    assign m_tuser = tuser_q;
`else
    assign m_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with W=4, H=2, gap=3 and a behavioural FWFT FIFO;
// m_tuser expectations follow FIFO_STREAM_READER_TUSER_EN.
module tb_fifo_stream_reader;
    localparam int DW    = 8;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int GAP   = 3;
    localparam int FRAME = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          m_tuser;
    logic          frame_done;
    logic          busy;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          eof;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] fifo_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            push_pos = 0;
    int            rd_pos = 0;
    int            acc_count = 0;
    int            fd_exp_cyc = -1000;
    int            last_eof_cyc = -1000;
    bit            b2b_mode = 1'b0;
    bit            b2b_armed = 1'b0;
    bit            pop_pend = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_user;
    bit            bp_mode = 1'b0;
    int            bp_phase = 0;

    fifo_stream_reader #(
        .C_DATA_WIDTH(DW),
        .C_IMG_WIDTH (W),
        .C_IMG_HEIGHT(H),
        .C_FRAME_GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t make_exp(input logic [DW-1:0] d, input int pos);
        exp_t e;
        e.data = d;
        e.last = ((pos % W) == W - 1);
`ifdef FIFO_STREAM_READER_TUSER_EN
        e.user = (pos == 0);
`else
        e.user = 1'b0;
`endif
        e.eof = (pos == FRAME - 1);
        return e;
    endfunction

    function automatic void refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    task automatic push_word(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(make_exp(d, push_pos));
        push_pos = (push_pos + 1) % FRAME;
        refresh_fifo();
    endtask

    // FIFO model: the pop decided at the preceding negedge happens at this edge.
    always @(posedge clk) begin
        cyc++;
        if (pop_pend) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_pend = 1'b0;
        end
        #1 refresh_fifo();
    end

    always @(negedge clk) begin
        if (rst) begin
            pop_pend   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            pop_pend = fifo_rd_en;
            if (fifo_rd_en) begin
                check_eq("rd_while_empty", fifo_empty, 0);
                if (rd_pos == 0 && b2b_armed) begin
                    check_eq("b2b_start_gap", cyc - last_eof_cyc, GAP + 2);
                    b2b_armed = 1'b0;
                end
                rd_pos = (rd_pos + 1) % FRAME;
            end
            if (prev_stall) begin
                check_eq("hold_tdata", m_tdata, prev_data);
                check_eq("hold_tlast", m_tlast, prev_last);
                check_eq("hold_tuser", m_tuser, prev_user);
            end
            if (m_tvalid && !m_tready) check_eq("rd_during_stall", fifo_rd_en, 0);
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            prev_user  = m_tuser;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_expected", exp_q.size() != 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("tdata", m_tdata, mon_e.data);
                    check_eq("tlast", m_tlast, mon_e.last);
                    check_eq("tuser", m_tuser, mon_e.user);
                    acc_count++;
                    if (mon_e.eof) begin
                        fd_exp_cyc   = cyc + 1;
                        last_eof_cyc = cyc;
                        if (b2b_mode) b2b_armed = 1'b1;
                    end
                end
            end
            if (frame_done || cyc == fd_exp_cyc) check_eq("frame_done", frame_done, cyc == fd_exp_cyc);
            if (cyc == fd_exp_cyc + GAP - 1) check_eq("busy_in_gap", busy, 1);
            if (cyc == fd_exp_cyc + GAP) check_eq("busy_low_after_gap", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (bp_mode) begin
            m_tready = (bp_phase == 0) || (bp_phase == 3);
            bp_phase = (bp_phase + 1) % 4;
        end
    endtask

    task automatic start_frame();
        int n = 0;
        en = 1'b1;
        tick();
        while (!busy && n < 50) begin
            tick();
            n++;
        end
        check_eq("start_in_budget", n < 50, 1);
        en = 1'b0;
    endtask

    task automatic wait_accepts(input int target);
        int n = 0;
        while (acc_count < target && n < 200) begin
            tick();
            n++;
        end
        check_eq("accepts_in_budget", n < 200, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && cyc > fd_exp_cyc + GAP) && n < 300) begin
            tick();
            n++;
        end
        check_eq("frame_in_budget", n < 300, 1);
        check_eq("exp_left", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_tvalid"}, m_tvalid, 0);
        check_eq({tag, "_tdata"}, m_tdata, 0);
        check_eq({tag, "_tlast"}, m_tlast, 0);
        check_eq({tag, "_tuser"}, m_tuser, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_rd_en"}, fifo_rd_en, 0);
    endtask

    // Reset mid-frame: the beat in the output register is dropped and whatever
    // remains in the FIFO becomes the start of a new frame.
    task automatic reset_pulse();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < fifo_q.size(); i++) exp_q.push_back(make_exp(fifo_q[i], i % FRAME));
        push_pos   = fifo_q.size() % FRAME;
        rd_pos     = 0;
        fd_exp_cyc = -1000;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_rst");
    endtask

    initial begin
        refresh_fifo();
        rst = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Free-flow
        m_tready = 1'b1;
        for (int i = 0; i < FRAME; i++) push_word(8'h10 + 8'(i));
        start_frame();
        wait_done();

        // Backpressure 1,0,0,1
        for (int i = 0; i < FRAME; i++) push_word(8'h20 + 8'(i));
        bp_phase = 0;
        bp_mode  = 1'b1;
        start_frame();
        wait_done();
        bp_mode  = 1'b0;
        m_tready = 1'b1;

        // Starvation after the third word
        for (int i = 0; i < 3; i++) push_word(8'h30 + 8'(i));
        start_frame();
        wait_accepts(acc_count + 3 - (acc_count % FRAME));
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("starve_tvalid", m_tvalid, 0);
            check_eq("starve_busy", busy, 1);
        end
        for (int i = 3; i < FRAME; i++) push_word(8'h30 + 8'(i));
        wait_done();

        // Back-to-back frames with en held high
        b2b_mode = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) push_word(8'h40 + 8'(i));
        en = 1'b1;
        wait_accepts(acc_count + FRAME + 1);
        en = 1'b0;
        b2b_mode = 1'b0;
        wait_done();
        check_eq("b2b_gap_seen", b2b_armed, 0);

        // Reset after three beats
        for (int i = 0; i < FRAME; i++) push_word(8'h50 + 8'(i));
        start_frame();
        wait_accepts(acc_count + 3 - (acc_count % FRAME));
        reset_pulse();
        for (int i = fifo_q.size(); i < FRAME; i++) push_word(8'h58 + 8'(i - fifo_q.size() + 8'(i)));
        start_frame();
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
